// File: rtl/any1_memport.sv
// Load/store bus sequencer: runs one or two 64-bit bus cycles per request and returns
// aligned, optionally sign-extended load data or a store completion.
module any1_memport #(
    parameter int TMO = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_ea,
    input  logic        req_we,
    input  logic [1:0]  req_sz,
    input  logic        req_sext,
    input  logic [63:0] req_wdat,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_dat,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [7:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [63:0] dat_o,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic [63:0] dat_i
);
    typedef enum logic [1:0] {IDLE, BUS1, BUS2, RESP} state_t;

    localparam logic [7:0] TLIM = 8'(TMO - 1);

    state_t       state;
    logic [31:0]  ea;
    logic [1:0]   sz;
    logic         sext;
    logic         we;
    logic         split;
    logic [15:0]  msk;
    logic [127:0] wimg;
    logic [63:0]  rlo;
    logic [7:0]   tcnt;

    logic [15:0]  req_lanes, req_msk;
    logic [127:0] req_img;
    logic         bus_act, tmo, go2, fin, fin_err;
    logic [127:0] rbuf;
    logic [63:0]  fin_dat;

    function automatic logic [63:0] fmt(input logic [127:0] r, input logic [2:0] off,
                                        input logic [1:0] s, input logic sx);
        logic [127:0] sh;
        sh = r >> {off, 3'b000};
        case (s)
            2'd0:    fmt = {{56{sx & sh[7]}},  sh[7:0]};
            2'd1:    fmt = {{48{sx & sh[15]}}, sh[15:0]};
            2'd2:    fmt = {{32{sx & sh[31]}}, sh[31:0]};
            default: fmt = sh[63:0];
        endcase
    endfunction

    always_comb begin
        case (req_sz)
            2'd0:    req_lanes = 16'h0001;
            2'd1:    req_lanes = 16'h0003;
            2'd2:    req_lanes = 16'h000F;
            default: req_lanes = 16'h00FF;
        endcase
        req_msk = req_lanes << req_ea[2:0];
        req_img = {64'b0, req_wdat} << {req_ea[2:0], 3'b000};
    end

    // The stb_o-low gap cycle at the start of BUS2 is not a waiting cycle.
    always_comb begin
        bus_act = (state == BUS1) || (state == BUS2 && stb_o);
        tmo     = (tcnt == TLIM);
        go2     = (state == BUS1) && ack_i && !err_i && split;
        fin     = bus_act && (err_i || (ack_i ? !go2 : tmo));
        fin_err = err_i || (!ack_i && tmo);
        rbuf    = (state == BUS2) ? {dat_i, rlo} : {64'b0, dat_i};
        fin_dat = (fin_err || we) ? 64'b0 : fmt(rbuf, ea[2:0], sz, sext);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_dat   <= '0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            sel_o      <= '0;
            adr_o      <= '0;
            dat_o      <= '0;
            ea         <= '0;
            sz         <= '0;
            sext       <= 1'b0;
            we         <= 1'b0;
            split      <= 1'b0;
            msk        <= '0;
            wimg       <= '0;
            rlo        <= '0;
            tcnt       <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    state     <= BUS1;
                    req_ready <= 1'b0;
                    ea        <= req_ea;
                    sz        <= req_sz;
                    sext      <= req_sext;
                    we        <= req_we;
                    msk       <= req_msk;
                    wimg      <= req_img;
                    split     <= |req_msk[15:8];
                    cyc_o     <= 1'b1;
                    stb_o     <= 1'b1;
                    we_o      <= req_we;
                    adr_o     <= {req_ea[31:3], 3'b000};
                    sel_o     <= req_msk[7:0];
                    dat_o     <= req_img[63:0];
                    tcnt      <= '0;
                end
                BUS1, BUS2: begin
                    if (fin) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= fin_err;
                        resp_dat   <= fin_dat;
                        cyc_o      <= 1'b0;
                        stb_o      <= 1'b0;
                        we_o       <= 1'b0;
                        sel_o      <= '0;
                        adr_o      <= '0;
                        dat_o      <= '0;
                    end else if (go2) begin
                        state <= BUS2;
                        rlo   <= dat_i;
                        stb_o <= 1'b0;
                        adr_o <= {ea[31:3], 3'b000} + 32'd8;
                        sel_o <= msk[15:8];
                        dat_o <= wimg[127:64];
                        tcnt  <= '0;
                    end else if (!stb_o) begin
                        stb_o <= 1'b1;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_dat   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_any1_memport.sv
// Scoreboard bench for any1_memport: bus slave checks each strobe against an expected
// bus-cycle queue, monitor checks each response against an expected response queue.
module tb_any1_memport;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_sext;
    logic [31:0] req_ea;
    logic [1:0]  req_sz;
    logic [63:0] req_wdat;
    logic        resp_valid, resp_err;
    logic [63:0] resp_dat;
    logic        cyc_o, stb_o, we_o;
    logic [7:0]  sel_o;
    logic [31:0] adr_o;
    logic [63:0] dat_o;
    logic        ack_i, err_i;
    logic [63:0] dat_i;

    any1_memport #(.TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_ea(req_ea), .req_we(req_we),
        .req_sz(req_sz), .req_sext(req_sext), .req_wdat(req_wdat),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_dat(resp_dat),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [7:0]  sel;
        logic        we;
        logic [63:0] wd;
        logic [63:0] rd;
        logic        err;
    } bus_t;

    typedef struct {
        logic        err;
        logic [63:0] dat;
        int          lat;
        int          acc;
    } rsp_t;

    bus_t bq[$];
    rsp_t sq[$];
    int   npass = 0, nchk = 0;
    int   cnt = 0, gap_cnt = 0, stb_cnt = 0;
    bit   mute = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    always @(posedge clk) cnt <= cnt + 1;

    // Bus slave: answers each strobe cycle with the next queued bus cycle.
    always @(negedge clk) begin
        bus_t        b;
        logic [63:0] lm;
        ack_i = 1'b0;
        err_i = 1'b0;
        if (cyc_o && !stb_o) gap_cnt++;
        if (cyc_o && stb_o) begin
            stb_cnt++;
            if (!mute) begin
                if (bq.size() == 0) check("bus_extra_cycle", 1, 0);
                else begin
                    b = bq.pop_front();
                    check("bus_adr", 64'(adr_o), 64'(b.adr));
                    check("bus_sel", 64'(sel_o), 64'(b.sel));
                    check("bus_we", 64'(we_o), 64'(b.we));
                    if (b.we) begin
                        lm = '0;
                        for (int i = 0; i < 8; i++) if (b.sel[i]) lm[i*8 +: 8] = 8'hFF;
                        check("bus_dat", dat_o & lm, b.wd & lm);
                    end
                    dat_i = b.rd;
                    if (b.err) err_i = 1'b1;
                    else ack_i = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        rsp_t r;
        if (resp_valid) begin
            if (sq.size() == 0) check("resp_extra", 1, 0);
            else begin
                r = sq.pop_front();
                check("resp_err", 64'(resp_err), 64'(r.err));
                check("resp_dat", resp_dat, r.dat);
                check("resp_lat", 64'(cnt - r.acc), 64'(r.lat));
            end
        end
    end

    task automatic push_bus(input logic [31:0] adr, input logic [7:0] sel, input logic we,
                            input logic [63:0] wd, input logic [63:0] rd, input logic err);
        bus_t b;
        b.adr = adr; b.sel = sel; b.we = we; b.wd = wd; b.rd = rd; b.err = err;
        bq.push_back(b);
    endtask

    task automatic issue(input logic [31:0] ea, input logic we, input logic [1:0] sz,
                         input logic sx, input logic [63:0] wd,
                         input logic eerr, input logic [63:0] edat, input int lat);
        rsp_t r;
        int   t;
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        check("req_ready", 64'(req_ready), 1);
        req_ea = ea; req_we = we; req_sz = sz; req_sext = sx; req_wdat = wd;
        req_valid = 1'b1;
        r.err = eerr; r.dat = edat; r.lat = lat; r.acc = cnt;
        sq.push_back(r);
        @(posedge clk);
        #1 req_valid = 1'b0;
        t = 0;
        while (sq.size() != 0 && t < 60) begin @(negedge clk); t++; end
        check("resp_seen", 64'(sq.size()), 0);
        check("bus_left", 64'(bq.size()), 0);
        sq.delete();
        bq.delete();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_ea = '0; req_we = 1'b0; req_sz = '0; req_sext = 1'b0; req_wdat = '0;
        ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
        #12;
        check("rst_ready", 64'(req_ready), 1);
        check("rst_cyc", 64'(cyc_o), 0);
        check("rst_stb", 64'(stb_o), 0);
        check("rst_resp", 64'(resp_valid), 0);
        check("rst_sel", 64'(sel_o), 0);
        check("rst_adr", 64'(adr_o), 0);
        @(negedge clk) rst = 1'b0;

        // octa load, aligned
        push_bus(32'h1000, 8'hFF, 0, 0, 64'h8877665544332211, 0);
        issue(32'h1000, 0, 2'd3, 0, 0, 0, 64'h8877665544332211, 2);

        // tetra load with sign extension, crossing the 8-byte boundary
        gap_cnt = 0;
        push_bus(32'h1000, 8'hC0, 0, 0, 64'hBBAA_1111_2222_3333, 0);
        push_bus(32'h1008, 8'h03, 0, 0, 64'h9999_8888_7777_DDCC, 0);
        issue(32'h1006, 0, 2'd2, 1, 0, 0, 64'hFFFFFFFFDDCCBBAA, 4);
        check("split_gap", 64'(gap_cnt), 1);

        // byte store
        push_bus(32'h2000, 8'h08, 1, 64'h0000_0000_5A00_0000, 0, 0);
        issue(32'h2003, 1, 2'd0, 0, 64'h5A, 0, 0, 2);

        // wyde store wrapping past the top of the address space
        push_bus(32'hFFFFFFF8, 8'h80, 1, 64'h3400_0000_0000_0000, 0, 0);
        push_bus(32'h00000000, 8'h01, 1, 64'h0000_0000_0000_0012, 0, 0);
        issue(32'hFFFFFFFF, 1, 2'd1, 0, 64'h1234, 0, 0, 4);

        // bus error on first half of a split load
        push_bus(32'h1000, 8'hC0, 0, 0, 64'hBBAA_1111_2222_3333, 1);
        issue(32'h1006, 0, 2'd2, 1, 0, 1, 0, 2);

        // byte load, sign-extended; wyde load, zero-extended
        push_bus(32'h3000, 8'h20, 0, 0, 64'h0000_8000_0000_0000, 0);
        issue(32'h3005, 0, 2'd0, 1, 0, 0, 64'hFFFFFFFFFFFFFF80, 2);
        push_bus(32'h3008, 8'h0C, 0, 0, 64'h0000_0000_F00D_0000, 0);
        issue(32'h300A, 0, 2'd1, 0, 0, 0, 64'h000000000000F00D, 2);

        // timeout: no ack at all
        mute = 1'b1;
        stb_cnt = 0;
        issue(32'h3000, 0, 2'd0, 0, 0, 1, 0, 1 + TMO);
        check("tmo_wait_cycles", 64'(stb_cnt), 64'(TMO));

        // reset in the middle of a bus cycle
        @(negedge clk);
        req_ea = 32'h4000; req_we = 1'b0; req_sz = 2'd3; req_sext = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_cyc", 64'(cyc_o), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_drop_cyc", 64'(cyc_o), 0);
        check("rst_drop_stb", 64'(stb_o), 0);
        check("rst_drop_ready", 64'(req_ready), 1);
        check("rst_drop_resp", 64'(resp_valid), 0);
        @(negedge clk) rst = 1'b0;
        mute = 1'b0;
        repeat (4) @(negedge clk);

        // unit still works after the reset
        push_bus(32'h1000, 8'hFF, 0, 0, 64'h0123456789ABCDEF, 0);
        issue(32'h1000, 0, 2'd3, 0, 0, 0, 64'h0123456789ABCDEF, 2);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/any1_memport.md
Name: any1_memport

Overview:
- Load/store bus sequencer. Consumes the effective address produced by the address generator, together with access size and store data.
- Runs one or two 64-bit bus cycles on the data bus and returns aligned, optionally sign-extended load data or a store completion to the memory stage.
- Splits accesses that cross an 8-byte boundary into two bus cycles.
- Reports bus errors and bus timeouts.

Parameters:
- TMO, 255: maximum cycles to wait for ack_i per bus cycle before a timeout error; 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle; request accepted when req_valid & req_ready
- req_ea  in  32  effective address (any byte alignment)
- req_we  in  1  1=store, 0=load
- req_sz  in  2  0=byte, 1=wyde(2), 2=tetra(4), 3=octa(8)
- req_sext  in  1  sign-extend load result
- req_wdat  in  64  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  bus error or timeout; qualified by resp_valid
- resp_dat  out  64  load result; 0 for stores and errors
- cyc_o  out  1  bus cycle
- stb_o  out  1  strobe
- we_o  out  1  write enable
- sel_o  out  8  byte lane selects
- adr_o  out  32  bus address, adr_o[2:0]=0
- dat_o  out  64  bus write data
- ack_i  in  1  bus acknowledge
- err_i  in  1  bus error
- dat_i  in  64  bus read data

Behaviour:
- Reset: async assert forces IDLE. All outputs are 0 except req_ready=1. Any in-flight bus cycle is dropped immediately; cyc_o and stb_o fall with rst.
- States: IDLE, BUS1, BUS2, RESP.
- On accept, register the request and compute:
  - n = 1<<req_sz
  - off = ea[2:0]
  - 16-bit mask M = ((1<<n)-1) << off
  - 128-bit store image W = req_wdat << (off*8)
  - split = |M[15:8]
- IDLE -> BUS1 on accept.
  - BUS1 drives cyc_o=stb_o=1, we_o=req_we, adr_o={ea[31:3],3'b0}, sel_o=M[7:0], dat_o=W[63:0].
  - First bus strobe is visible the cycle after accept.
- BUS1, ack_i:
  - Latch dat_i into the low half of read buffer R.
  - If split: go to BUS2. stb_o=0 for one cycle; cyc_o stays 1.
  - Otherwise go to RESP.
- BUS2 drives adr_o={ea[31:3],3'b0}+8, sel_o=M[15:8], dat_o=W[127:64].
  - Address wraps modulo 2^32.
  - ack_i latches dat_i into the high half of R, then go to RESP.
- err_i (priority over ack_i) in BUS1 or BUS2: go to RESP with resp_err=1. BUS2 is skipped.
- Timeout:
  - A counter clears on entry to BUS1 and BUS2 and increments each cycle without ack_i/err_i.
  - When it reaches TMO, go to RESP with resp_err=1.
- RESP:
  - cyc_o=stb_o=sel_o=0, resp_valid=1 for exactly one cycle, then IDLE.
  - Load: resp_dat = (R >> off*8) truncated to n bytes. If req_sext, sign-extend from bit 8n-1; otherwise zero-extend.
  - Stores and errors: resp_dat=0.
- req_ready is 1 only in IDLE. The unit is unpipelined; no new request is accepted in the RESP cycle.
- Latency, unsplit access with ack in the first strobe cycle: accept at t0, strobe t1, resp_valid t2. A split access adds 2 cycles.
- ack_i outside BUS1/BUS2 is ignored.

Test Plan:
- Load octa ea=0x1000, dat_i=0x8877665544332211 ack on first strobe -> adr_o=0x1000, sel_o=0xFF, resp_valid 2 cycles after accept, resp_dat=0x8877665544332211, resp_err=0.
- Load tetra sext ea=0x1006:
  - First cycle adr 0x1000 sel 0xC0, dat_i=0xBBAA_xxxx_xxxx_xxxx.
  - Second cycle adr 0x1008 sel 0x03, dat_i=0x...0000_DDCC.
  - -> resp_dat=0xFFFFFFFFDDCCBBAA. cyc_o held high throughout; one stb_o gap between halves.
- Store byte ea=0x2003 wdat=0x5A -> adr_o=0x2000, sel_o=0x08, dat_o[31:24]=0x5A, we_o=1, resp_dat=0, resp_err=0.
- Store wyde ea=0xFFFFFFFF -> first cycle adr 0xFFFFFFF8 sel 0x80; second cycle adr 0x00000000 sel 0x01.
- err_i on first half of a split load -> no second cycle, resp_err=1, resp_dat=0.
- No ack with TMO=4 -> resp_err=1 after 4 waiting cycles. Separately, assert rst while cyc_o=1 -> cyc_o=0 immediately, req_ready=1, no resp_valid.
